// File: rtl/instr_fetch_unit_if.sv
// Fetch-to-decode bundle for instr_fetch_unit: ROM port, redirect port,
// fetch enable, the decode-side valid/ready stream and the halt status.
// The master modport is the fetch unit's view. The slave modport is the
// view of the surrounding ROM and decode logic.
interface instr_fetch_unit_if #(
  parameter int PC_W    = 3,
  parameter int INSTR_W = 16
);
  logic               en;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               if_valid;
  logic               if_ready;
  logic [INSTR_W-1:0] if_instr;
  logic [PC_W-1:0]    if_pc;
  logic               halted;

  modport master (
    input  en, imem_rdata, redirect_valid, redirect_pc, if_ready,
    output imem_addr, if_valid, if_instr, if_pc, halted
  );

  modport slave (
    output en, imem_rdata, redirect_valid, redirect_pc, if_ready,
    input  imem_addr, if_valid, if_instr, if_pc, halted
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and reads the combinational instruction ROM.
// It buffers {pc, instr} pairs in a 2-entry queue and presents them to decode
// over a valid/ready handshake. A redirect flushes the queue and reloads the PC.
// Optional feature macro: IFETCH_HALT_EN. When it is defined, an opcode of 4'hF
// in the top nibble stops fetching after that instruction has been queued.
// Slot 0 of the queue is always the head, so every output comes straight from
// a register.
module instr_fetch_unit #(
  parameter int PC_W     = 3,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic                clk,
  input  logic                rst,
  instr_fetch_unit_if.master  bus
);

  logic [1:0]         count_reg, count_next;
  logic               valid_reg;
  logic [PC_W-1:0]    pc_reg, pc_next;
  logic [PC_W-1:0]    q_pc_reg    [2];
  logic [PC_W-1:0]    q_pc_next   [2];
  logic [INSTR_W-1:0] q_instr_reg [2];
  logic [INSTR_W-1:0] q_instr_next[2];
  logic               halted_reg;
  logic               pop, push;

  // Handshake decisions plus next queue, count and PC; redirect overrides everything
  always_comb begin
    pop          = valid_reg & bus.if_ready;
    push         = bus.en & ~halted_reg & ~bus.redirect_valid &
                   ((count_reg != 2'd2) | pop);
    count_next   = count_reg;
    pc_next      = pc_reg;
    q_pc_next    = q_pc_reg;
    q_instr_next = q_instr_reg;
    if (bus.redirect_valid) begin
      count_next = 2'd0;
      pc_next    = bus.redirect_pc;
    end else begin
      if (push) begin
        pc_next = pc_reg + PC_W'(1);
      end
      case ({push, pop})
        2'b10: begin
          // Append at the tail: slot 0 when empty, otherwise slot 1
          if (count_reg == 2'd0) begin
            q_pc_next[0]    = pc_reg;
            q_instr_next[0] = bus.imem_rdata;
          end else begin
            q_pc_next[1]    = pc_reg;
            q_instr_next[1] = bus.imem_rdata;
          end
          count_next = count_reg + 2'd1;
        end
        2'b01: begin
          // Advance the second entry to the head; a lone head simply stays as stale data
          if (count_reg == 2'd2) begin
            q_pc_next[0]    = q_pc_reg[1];
            q_instr_next[0] = q_instr_reg[1];
          end
          count_next = count_reg - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push: occupancy is unchanged, contents shift by one
          if (count_reg == 2'd2) begin
            q_pc_next[0]    = q_pc_reg[1];
            q_instr_next[0] = q_instr_reg[1];
            q_pc_next[1]    = pc_reg;
            q_instr_next[1] = bus.imem_rdata;
          end else begin
            q_pc_next[0]    = pc_reg;
            q_instr_next[0] = bus.imem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state: PC, occupancy and a registered copy of "queue not empty"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_reg    <= PC_W'(RESET_PC);
      count_reg <= 2'd0;
      valid_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
      valid_reg <= (count_next != 2'd0);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      // Queue slot storage, cleared on reset so the head reads as zero
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_pc_reg[gi]    <= '0;
          q_instr_reg[gi] <= '0;
        end else begin
          q_pc_reg[gi]    <= q_pc_next[gi];
          q_instr_reg[gi] <= q_instr_next[gi];
        end
      end
    end
  endgenerate

`ifdef IFETCH_HALT_EN
  logic halt_op;
  assign halt_op = (bus.imem_rdata[INSTR_W-1 -: 4] == 4'hF);

  // Halt latches when a HALT opcode is enqueued; only a redirect or reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_reg <= 1'b0;
    end else if (bus.redirect_valid) begin
      halted_reg <= 1'b0;
    end else if (push && halt_op) begin
      halted_reg <= 1'b1;
    end
  end
`else
  assign halted_reg = 1'b0;
`endif

  assign bus.imem_addr = pc_reg;
  assign bus.if_valid  = valid_reg;
  assign bus.if_pc     = q_pc_reg[0];
  assign bus.if_instr  = q_instr_reg[0];
  assign bus.halted    = halted_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. A queue-based reference model runs in
// lock-step with the DUT. It covers directed reset, streaming, stall, redirect,
// mid-stream reset, en=0 and halt scenarios, followed by a randomized phase.
module tb_instr_fetch_unit;

`ifdef IFETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.PC_W(3), .INSTR_W(16)) bus ();

  instr_fetch_unit #(.PC_W(3), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom [8];
  assign bus.imem_rdata = rom[bus.imem_addr];

  typedef struct {
    int          pc;
    logic [15:0] instr;
  } entry_t;

  entry_t mq[$];
  int     m_pc;
  bit     m_halted;
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic load_rom();
    for (int i = 0; i < 8; i++) rom[i] = 16'h1000 + 16'(i);
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc     = 0;
    m_halted = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".if_valid"}, 32'(bus.if_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check_val({tag, ".if_pc"},    32'(bus.if_pc),    32'(mq[0].pc));
      check_val({tag, ".if_instr"}, 32'(bus.if_instr), 32'(mq[0].instr));
    end
    check_val({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'(m_pc));
    check_val({tag, ".halted"},    32'(bus.halted),    32'(m_halted));
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, ".if_valid"},  32'(bus.if_valid),  32'd0);
    check_val({tag, ".if_instr"},  32'(bus.if_instr),  32'd0);
    check_val({tag, ".if_pc"},     32'(bus.if_pc),     32'd0);
    check_val({tag, ".imem_addr"}, 32'(bus.imem_addr), 32'd0);
    check_val({tag, ".halted"},    32'(bus.halted),    32'd0);
  endtask

  // Called just after a falling edge: drive inputs, advance the model over the
  // rising edge, then compare on the next falling edge.
  task automatic step(input string tag, input bit en, input bit rdy,
                      input bit redir, input int rpc);
    bit          pop, push;
    logic [15:0] fetched;
    bus.en             = en;
    bus.if_ready       = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = 3'(rpc);
    fetched = rom[m_pc];
    pop  = (mq.size() > 0) && rdy;
    push = en && !m_halted && !redir && (mq.size() < 2 || pop);
    @(posedge clk);
    if (redir) begin
      mq.delete();
      m_pc     = rpc;
      m_halted = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: m_pc, instr: fetched});
        m_pc = (m_pc + 1) % 8;
        if (HALT_EN && fetched[15:12] == 4'hF) m_halted = 1;
      end
    end
    @(negedge clk);
    $display("%s en=%0b rdy=%0b redir=%0b/%0d -> valid=%0b pc=%0d instr=%h addr=%0d halted=%0b",
             tag, en, rdy, redir, rpc, bus.if_valid, bus.if_pc, bus.if_instr,
             bus.imem_addr, bus.halted);
    check_outputs(tag);
  endtask

  // Reset asserted just after a falling edge, released on the next falling edge
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values({tag, ".rel"});
  endtask

  initial begin
    bus.en             = 1'b1;
    bus.if_ready       = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    load_rom();
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_values("reset0");
    #9;
    rst = 1'b0;
    #1;
    check_reset_values("reset0.rel");

    // Continuous streaming with PC wrap
    for (int i = 0; i < 11; i++) step("stream", 1, 1, 0, 0);

    // Stall decode for 5 cycles, then resume
    do_reset("rst_stall");
    for (int i = 0; i < 5; i++) step("stall", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("resume", 1, 1, 0, 0);

    // Redirect while the queue is full
    for (int i = 0; i < 3; i++) step("fill", 1, 0, 0, 0);
    step("redirect", 1, 0, 1, 5);
    for (int i = 0; i < 5; i++) step("post_redir", 1, 1, 0, 0);

    // Mid-stream reset while if_valid is high
    check_val("midrst.pre_valid", 32'(bus.if_valid), 32'd1);
    do_reset("midrst");
    for (int i = 0; i < 3; i++) step("restart", 1, 1, 0, 0);

    // en=0 with two entries queued: both drain, then the PC holds
    for (int i = 0; i < 3; i++) step("fill2", 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step("en_off", 0, 1, 0, 0);

    // HALT opcode at address 3
    rom[3] = 16'hF000;
    do_reset("rst_halt");
    for (int i = 0; i < 8; i++) step("halt", 1, 1, 0, 0);
    step("halt_redir", 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step("after_halt", 1, 1, 0, 0);

    // Randomized traffic against a random ROM
    for (int i = 0; i < 8; i++) rom[i] = 16'($urandom);
    rom[$urandom_range(0, 7)] = 16'hF123;
    do_reset("rst_rand");
    for (int i = 0; i < 400; i++) begin
      step("rand",
           ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 99) < 8),
           int'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
